controlador_envase_param: RTL and testbench

//  Parametrised successor of the fill/seal line controller. One FSM drives conveyor (m), fill valve (ev) and sealer (ve).

---
 rtl/envase_pkg.sv | 14 +
 rtl/contador_mod_n.sv | 23 ++
 rtl/controlador_envase_param.sv | 118 +++++++++++
 tb/tb_controlador_envase_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/envase_pkg.sv
// Shared definitions for the fill/seal line controller: FSM state encoding.
package envase_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        FILL  = 3'd2,
        SEAL  = 3'd3,
        ALARM = 3'd4
    } state_t;

endpackage

// File: rtl/contador_mod_n.sv
// Modulo-N up counter with synchronous clear; wrap flags the increment that rolls N-1 back to 0.
module contador_mod_n #(
    parameter int unsigned N = 12,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = inc && (q == W'(N - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/controlador_envase_param.sv
// Fill/seal line controller: conveyor/valve/sealer FSM, saturating cork reservoir
// with auto-refill, and units/dozens batch counting.
module controlador_envase_param
    import envase_pkg::*;
#(
    parameter int unsigned CW           = 7,
    parameter int unsigned CORK_MAX     = 99,
    parameter int unsigned MIN_CORKS    = 5,
    parameter int unsigned REFILL_AMT   = 20,
    parameter int unsigned DOZEN_MAX    = 10,
    parameter int unsigned DW           = 4,
    parameter int unsigned SEAL_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                pg,
    input  logic                ch,
    input  logic                cq,
    input  logic                op_load,
    input  logic [CW-1:0]       op_amount,
    output logic                m,
    output logic                ev,
    output logic                ve,
    output logic                al,
    output logic [STATE_W-1:0]  state,
    output logic [CW-1:0]       cork_count,
    output logic [3:0]          units,
    output logic [DW-1:0]       dozens,
    output logic                batch_done
);

    localparam int unsigned XW = CW + 2;
    localparam int unsigned TW = $clog2(SEAL_TIMEOUT + 1);

    state_t        st, st_nxt;
    logic [TW-1:0] seal_tmr;
    logic          en_prev, en_rise, seal_ok, timeout, auto_refill;
    logic          cnt_clr, units_wrap, dozens_wrap;
    logic [XW-1:0] cork_sum;
    logic [CW-1:0] cork_nxt;

    assign state       = st;
    assign en_rise     = en & ~en_prev;
    assign seal_ok     = (st == SEAL) & cq;
    assign timeout     = (st == SEAL) & ~cq & (seal_tmr == TW'(SEAL_TIMEOUT - 1));
    assign auto_refill = (cork_count < CW'(MIN_CORKS)) & ~op_load;
    assign cnt_clr     = clr | en_rise;

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (en) st_nxt = (cork_count == '0) ? ALARM : MOVE;
            MOVE: begin
                if (!en)                     st_nxt = IDLE;
                else if (cork_count == '0)   st_nxt = ALARM;
                else if (pg)                 st_nxt = FILL;
            end
            FILL:    if (ch) st_nxt = SEAL;
            SEAL: begin
                if (cq)                      st_nxt = en ? MOVE : IDLE;
                else if (timeout)            st_nxt = ALARM;
            end
            ALARM:   if (!en && cork_count != '0) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Widened sum so load + refill cannot overflow before the clamp to CORK_MAX.
    always_comb begin
        cork_sum = XW'(cork_count);
        if (op_load)     cork_sum = cork_sum + XW'(op_amount);
        if (auto_refill) cork_sum = cork_sum + XW'(REFILL_AMT);
        if (seal_ok && cork_sum != '0) cork_sum = cork_sum - XW'(1);
        cork_nxt = (cork_sum > XW'(CORK_MAX)) ? CW'(CORK_MAX) : cork_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st         <= IDLE;
            m          <= 1'b0;
            ev         <= 1'b0;
            ve         <= 1'b0;
            al         <= 1'b0;
            cork_count <= '0;
            seal_tmr   <= '0;
            en_prev    <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            st         <= st_nxt;
            m          <= (st_nxt == MOVE);
            ev         <= (st_nxt == FILL);
            ve         <= (st_nxt == SEAL);
            al         <= (st_nxt == ALARM);
            cork_count <= cork_nxt;
            seal_tmr   <= (st == SEAL && st_nxt == SEAL) ? seal_tmr + TW'(1) : '0;
            en_prev    <= en;
            batch_done <= dozens_wrap & ~en_rise;
        end
    end

    contador_mod_n #(.N(12), .W(4)) u_units (
        .clk  (clk),
        .clr  (cnt_clr),
        .inc  (seal_ok),
        .q    (units),
        .wrap (units_wrap)
    );

    contador_mod_n #(.N(DOZEN_MAX), .W(DW)) u_dozens (
        .clk  (clk),
        .clr  (cnt_clr),
        .inc  (units_wrap),
        .q    (dozens),
        .wrap (dozens_wrap)
    );

endmodule

// File: tb/tb_controlador_envase_param.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, queued at drive time.
module tb_controlador_envase_param;

    logic       clk = 1'b0;
    logic       clr, en, pg, ch, cq, op_load;
    logic [6:0] op_amount;
    logic       m, ev, ve, al, batch_done;
    logic [2:0] state;
    logic [6:0] cork_count;
    logic [3:0] units, dozens;

    controlador_envase_param #(
        .CW(7), .CORK_MAX(99), .MIN_CORKS(5), .REFILL_AMT(20),
        .DOZEN_MAX(10), .DW(4), .SEAL_TIMEOUT(8)
    ) dut (
        .clk(clk), .clr(clr), .en(en), .pg(pg), .ch(ch), .cq(cq),
        .op_load(op_load), .op_amount(op_amount),
        .m(m), .ev(ev), .ve(ve), .al(al), .state(state),
        .cork_count(cork_count), .units(units), .dozens(dozens),
        .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int outs;
        int cork;
        int u;
        int d;
        int bd;
    } exp_t;

    exp_t  sb_q[$];
    int    n_chk = 0, n_pass = 0;
    string phase = "reset";
    int    bd_seen = 0;

    // model state
    int ms = 0, mc = 0, mu = 0, md = 0, mt = 0, mep = 0, mbd = 0;

    task automatic chk(input string tag, input int got, input int exp_v);
        n_chk++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s.%s: got %0d, expected %0d", phase, tag, got, exp_v);
    endtask

    task automatic model_step();
        int ns, c;
        bit sok, rise, auto_r;
        if (clr) begin
            ms = 0; mc = 0; mu = 0; md = 0; mt = 0; mep = 0; mbd = 0;
            return;
        end
        ns  = ms;
        sok = (ms == 3) && cq;
        if (ms == 0) begin
            if (en) ns = (mc == 0) ? 4 : 1;
        end else if (ms == 1) begin
            if (!en) ns = 0;
            else if (mc == 0) ns = 4;
            else if (pg) ns = 2;
        end else if (ms == 2) begin
            if (ch) ns = 3;
        end else if (ms == 3) begin
            if (cq) ns = en ? 1 : 0;
            else if (mt + 1 == 8) ns = 4;
        end else begin
            if (!en && mc > 0) ns = 0;
        end
        mt = (ms == 3 && ns == 3) ? mt + 1 : 0;
        rise = en && (mep == 0);
        mbd = 0;
        if (rise) begin
            mu = 0; md = 0;
        end else if (sok) begin
            mu++;
            if (mu == 12) begin
                mu = 0; md++;
                if (md == 10) begin md = 0; mbd = 1; end
            end
        end
        auto_r = (mc < 5) && !op_load;
        c = mc - (sok ? 1 : 0) + (op_load ? int'(op_amount) : 0) + (auto_r ? 20 : 0);
        if (c < 0) c = 0;
        if (c > 99) c = 99;
        mc  = c;
        mep = en ? 1 : 0;
        ms  = ns;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.st   = ms;
        e.outs = {28'd0, ms == 1, ms == 2, ms == 3, ms == 4};
        e.cork = mc; e.u = mu; e.d = md; e.bd = mbd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("state", int'(state), e.st);
        chk("outs", int'({m, ev, ve, al}), e.outs);
        chk("cork", int'(cork_count), e.cork);
        chk("units", int'(units), e.u);
        chk("dozens", int'(dozens), e.d);
        chk("batch_done", int'(batch_done), e.bd);
        bd_seen += int'(batch_done);
    endtask

    task automatic clear_and_load(input int amt);
        clr = 1'b1; en = 1'b0; pg = 1'b0; ch = 1'b0; cq = 1'b0; op_load = 1'b0;
        tick();
        clr = 1'b0; op_load = 1'b1; op_amount = 7'(amt);
        tick();
        op_load = 1'b0;
    endtask

    task automatic bottle();
        pg = 1'b1; tick(); pg = 1'b0;
        ch = 1'b1; tick(); ch = 1'b0;
        cq = 1'b1; tick(); cq = 1'b0;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; pg = 1'b0; ch = 1'b0; cq = 1'b0;
        op_load = 1'b0; op_amount = '0;
        tick(); tick();
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({m, ev, ve, al, batch_done}), 0);
        chk("rst_cork", int'(cork_count), 0);

        phase = "t1_cycle";
        clear_and_load(30);
        chk("loaded", int'(cork_count), 30);
        en = 1'b1; tick();
        chk("move", int'({state, m, ev, ve}), {3'd1, 3'b100});
        pg = 1'b1; tick(); pg = 1'b0;
        chk("fill", int'({state, m, ev, ve}), {3'd2, 3'b010});
        ch = 1'b1; tick(); ch = 1'b0;
        chk("seal", int'({state, m, ev, ve}), {3'd3, 3'b001});
        cq = 1'b1; tick(); cq = 1'b0;
        chk("back_move", int'(state), 1);
        chk("cork_used", int'(cork_count), 29);
        chk("units1", int'(units), 1);

        phase = "t2_refill";
        clear_and_load(6);
        en = 1'b1; tick();
        bottle();
        chk("cork5", int'(cork_count), 5);
        bottle();
        chk("cork4", int'(cork_count), 4);
        tick();
        chk("auto24", int'(cork_count), 24);

        phase = "t3_sat_alarm";
        clear_and_load(98);
        en = 1'b1; tick();
        pg = 1'b1; tick(); pg = 1'b0;
        ch = 1'b1; tick(); ch = 1'b0;
        cq = 1'b1; op_load = 1'b1; op_amount = 7'd10; tick();
        cq = 1'b0; op_load = 1'b0;
        chk("saturate", int'(cork_count), 99);
        clr = 1'b1; en = 1'b0; tick(); clr = 1'b0;
        en = 1'b1; tick();
        chk("alarm", int'({state, al}), {3'd4, 1'b1});
        tick();
        chk("alarm_held", int'(state), 4);
        en = 1'b0; op_load = 1'b1; op_amount = 7'd5; tick(); op_load = 1'b0;
        chk("alarm_exit", int'({state, al}), {3'd0, 1'b0});

        phase = "t4_timeout";
        clear_and_load(30);
        en = 1'b1; tick();
        pg = 1'b1; tick(); pg = 1'b0;
        ch = 1'b1; tick(); ch = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("still_seal", int'(state), 3);
        tick();
        chk("timeout_alarm", int'({state, al}), {3'd4, 1'b1});
        chk("cork_kept", int'(cork_count), 30);
        chk("units_kept", int'(units), 0);
        en = 1'b0; tick();

        phase = "t5_batch";
        clear_and_load(50);
        en = 1'b1; tick();
        bd_seen = 0;
        for (int b = 1; b <= 119; b++) bottle();
        chk("pre_units", int'(units), 11);
        chk("pre_dozens", int'(dozens), 9);
        chk("no_early_pulse", bd_seen, 0);
        bottle();
        chk("pulse_on_120", int'(batch_done), 1);
        chk("post_units", int'(units), 0);
        chk("post_dozens", int'(dozens), 0);
        tick();
        chk("pulse_once", bd_seen, 1);
        en = 1'b0; tick();

        phase = "t6_stop_clr";
        clear_and_load(30);
        en = 1'b1; tick();
        pg = 1'b1; tick(); pg = 1'b0;
        en = 1'b0; tick();
        chk("fill_ignores_en", int'(state), 2);
        ch = 1'b1; tick(); ch = 1'b0;
        cq = 1'b1; tick(); cq = 1'b0;
        chk("seal_then_idle", int'(state), 0);
        chk("counted", int'(units), 1);
        en = 1'b1; tick();
        chk("rerun_clears", int'(units), 0);
        pg = 1'b1; tick(); pg = 1'b0;
        ch = 1'b1; tick(); ch = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0; en = 1'b0;
        chk("clr_all", int'({state, m, ev, ve, al, batch_done}), 0);
        chk("clr_cork", int'(cork_count), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
